// File: rtl/spram_pkg.sv
// Shared types and defaults for the single-port RAM access front-end.
// Holds the controller state enum, default geometry and the arbiter grant encoding.
package spram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/spram_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grants plus a one-bit memory
// of which side was granted last. Shared by the memory front-ends.
module spram_rr_arb2
  import spram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_grant;

  // On contention the side that did not win last time gets the port.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (en) begin
      if (req_wr && (!req_rd || last_grant == GNT_RD)) begin
        gnt_wr = 1'b1;
      end else if (req_rd) begin
        gnt_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_RD;
    end else if (gnt_wr) begin
      last_grant <= GNT_WR;
    end else if (gnt_rd) begin
      last_grant <= GNT_RD;
    end
  end

endmodule

// File: rtl/spram_access_ctrl.sv
// Request front-end for a single-port RAM: arbitrates write/read streams onto one port
// and returns read data. Define SPRAM_INIT_CLEAR_EN to zero the RAM after every reset.
module spram_access_ctrl
  import spram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  state_t        state;
  logic          run_en;
  logic [RD_LAT:0] rd_sr;

`ifdef SPRAM_INIT_CLEAR_EN
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_t          state_nx;
  logic [ADDR_W:0] clr_cnt;
  logic [ADDR_W:0] clr_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // The counter carries one extra bit so the cycle after the last clear write is visible.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    case (state)
      ST_INIT: begin
        if (clr_cnt[ADDR_W]) begin
          state_nx = ST_RUN;
        end else begin
          clr_cnt_nx = clr_cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_INIT;
      end
    endcase
  end
`else
  assign state = ST_RUN;
`endif

  // Ready is held low while reset is asserted so no handshake completes under reset.
  assign run_en    = rst_n && (state == ST_RUN);
  assign init_done = (state == ST_RUN);

  spram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .req_wr(wr_valid),
    .req_rd(rd_valid),
    .gnt_wr(wr_ready),
    .gnt_rd(rd_ready)
  );

  // The valid shift register is one stage longer than the RAM latency so the response
  // register samples dout exactly when the requested word is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rd_sr     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      ram_we <= 1'b0;
`ifdef SPRAM_INIT_CLEAR_EN
      if (state == ST_INIT) begin
        if (!clr_cnt[ADDR_W]) begin
          ram_we   <= 1'b1;
          ram_addr <= clr_cnt[ADDR_W-1:0];
          ram_din  <= '0;
        end
      end else
`endif
      if (wr_ready) begin
        ram_we   <= 1'b1;
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (rd_ready) begin
        ram_addr <= rd_addr;
      end
      rd_sr     <= {rd_sr[RD_LAT-1:0], rd_ready};
      rsp_valid <= rd_sr[RD_LAT];
      if (rd_sr[RD_LAT]) begin
        rsp_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Scoreboard bench for spram_access_ctrl: two instances (RD_LAT 1 and 2) share one
// request stream; a reference memory predicts read data and response timing.
module tb_spram_access_ctrl;
  import spram_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SPRAM_INIT_CLEAR_EN
  localparam logic INIT_DONE_RST = 1'b0;
`else
  localparam logic INIT_DONE_RST = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic rd_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic [1:0] wr_ready, rd_ready, rsp_valid, ram_we, init_done;
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_din [2];
  logic [DW-1:0] ram_dout [2];
  logic [DW-1:0] rsp_data [2];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int flush_base = 0;
  int rd_idx [2];

  logic [DW-1:0] ref_mem [DEPTH];
  logic model_last;
  logic [DW-1:0] exp_data [$];
  int exp_cyc [$];
  logic wa_d, ra_d, ob_d;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready[0]), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0]),
    .init_done(init_done[0])
  );

  spram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready[1]), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1]),
    .init_done(init_done[1])
  );

  // Behavioural single-port RAMs with read latency k+1; contents survive reset.
  for (genvar k = 0; k < 2; k++) begin : g_ram
    localparam int LAT = k + 1;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pipe [LAT];
    initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end
    always @(posedge clk) begin
      if (ram_we[k]) mem[ram_addr[k]] <= ram_din[k];
      pipe[0] <= mem[ram_addr[k]];
      for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign ram_dout[k] = pipe[LAT-1];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s ram_we[%0d]", tag, k), 32'(ram_we[k]), 32'(0));
      checkOutput($sformatf("%s ram_addr[%0d]", tag, k), 32'(ram_addr[k]), 32'(0));
      checkOutput($sformatf("%s ram_din[%0d]", tag, k), 32'(ram_din[k]), 32'(0));
      checkOutput($sformatf("%s rsp_valid[%0d]", tag, k), 32'(rsp_valid[k]), 32'(0));
      checkOutput($sformatf("%s rsp_data[%0d]", tag, k), 32'(rsp_data[k]), 32'(0));
      checkOutput($sformatf("%s wr_ready[%0d]", tag, k), 32'(wr_ready[k]), 32'(0));
      checkOutput($sformatf("%s rd_ready[%0d]", tag, k), 32'(rd_ready[k]), 32'(0));
      checkOutput($sformatf("%s init_done[%0d]", tag, k), 32'(init_done[k]), 32'(INIT_DONE_RST));
    end
  endtask

  // Drive one cycle of requests, check the grant against the round-robin rule and
  // update the reference memory / expected-response queue for accepted transfers.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra,
                               output logic wacc, output logic racc, output logic obs_w);
    logic exp_w, exp_r;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    @(negedge clk);
    exp_w = wv && (!rv || model_last == GNT_RD);
    exp_r = rv && !exp_w;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("wr_ready[%0d]", k), 32'(wr_ready[k]), 32'(exp_w));
      checkOutput($sformatf("rd_ready[%0d]", k), 32'(rd_ready[k]), 32'(exp_r));
      checkOutput($sformatf("init_done[%0d]", k), 32'(init_done[k]), 32'(1));
    end
    obs_w = wr_ready[0];
    if (exp_w) begin
      ref_mem[wa] = wd;
      model_last = GNT_WR;
    end
    if (exp_r) begin
      exp_data.push_back(ref_mem[ra]);
      exp_cyc.push_back(cyc);
      model_last = GNT_RD;
    end
    wacc = exp_w;
    racc = exp_r;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic runRandom(input int n);
    logic pw, pr, wacc, racc, ob;
    logic [AW-1:0] pwa, pra;
    logic [DW-1:0] pwd;
    pw = 1'b0; pr = 1'b0; pwa = '0; pra = '0; pwd = '0;
    repeat (n) begin
      if (!pw && $urandom_range(0, 3) != 0) begin
        pw = 1'b1; pwa = AW'($urandom); pwd = DW'($urandom);
      end
      if (!pr && $urandom_range(0, 3) != 0) begin
        pr = 1'b1; pra = AW'($urandom);
      end
      applyStimulus(pw, pwa, pwd, pr, pra, wacc, racc, ob);
      if (wacc) pw = 1'b0;
      if (racc) pr = 1'b0;
    end
  endtask

`ifdef SPRAM_INIT_CLEAR_EN
  task automatic checkInit();
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("init ram_we[%0d]", k), 32'(ram_we[k]), 32'(1));
        checkOutput($sformatf("init ram_addr[%0d]", k), 32'(ram_addr[k]), 32'(i));
        checkOutput($sformatf("init ram_din[%0d]", k), 32'(ram_din[k]), 32'(0));
        checkOutput($sformatf("init init_done[%0d]", k), 32'(init_done[k]), 32'(0));
        checkOutput($sformatf("init wr_ready[%0d]", k), 32'(wr_ready[k]), 32'(0));
        checkOutput($sformatf("init rd_ready[%0d]", k), 32'(rd_ready[k]), 32'(0));
      end
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("init end init_done[%0d]", k), 32'(init_done[k]), 32'(1));
      checkOutput($sformatf("init end ram_we[%0d]", k), 32'(ram_we[k]), 32'(0));
    end
    @(posedge clk);
    #1;
  endtask
`endif

  // Monitor: every response must match the oldest outstanding read, in data and in cycle.
  initial begin
    int idx;
    rd_idx[0] = 0;
    rd_idx[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rd_idx[k] < flush_base) rd_idx[k] = flush_base;
        idx = rd_idx[k];
        if (rsp_valid[k]) begin
          if (idx >= exp_data.size()) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL rsp_unexpected[%0d]: got rsp_valid=1 data 0x%0h expected no response (cycle %0d)",
                     k, rsp_data[k], cyc);
          end else begin
            checkOutput($sformatf("rsp_data[%0d] #%0d", k, idx), 32'(rsp_data[k]), 32'(exp_data[idx]));
            checkOutput($sformatf("rsp_cycle[%0d] #%0d", k, idx), 32'(cyc), 32'(exp_cyc[idx] + k + 3));
            rd_idx[k] = idx + 1;
          end
        end else if (idx < exp_data.size() && cyc > exp_cyc[idx] + k + 3) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL rsp_missing[%0d] #%0d: got no response expected one by cycle %0d (cycle %0d)",
                   k, idx, exp_cyc[idx] + k + 3, cyc);
          rd_idx[k] = idx + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] pattern;
    logic [AW-1:0] wa, ra;
    model_last = GNT_RD;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 6'h05; rd_addr = 6'h07; wr_data = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rst_n = 1'b1;

`ifdef SPRAM_INIT_CLEAR_EN
    checkInit();
    applyStimulus(1'b0, '0, '0, 1'b1, 6'h2A, wa_d, ra_d, ob_d);
`else
    applyStimulus(1'b1, 6'h00, 8'h11, 1'b0, '0, wa_d, ra_d, ob_d);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("first write ram_we[%0d]", k), 32'(ram_we[k]), 32'(1));
      checkOutput($sformatf("first write ram_din[%0d]", k), 32'(ram_din[k]), 32'(8'h11));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, wa_d, ra_d, ob_d);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("idle ram_we[%0d]", k), 32'(ram_we[k]), 32'(0));
`endif

    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b1, AW'(a), DW'($urandom), 1'b0, '0, wa_d, ra_d, ob_d);

    applyStimulus(1'b1, 6'h11, 8'h5C, 1'b0, '0, wa_d, ra_d, ob_d);
    applyStimulus(1'b0, '0, '0, 1'b1, 6'h11, wa_d, ra_d, ob_d);

    wa = 6'h20;
    ra = 6'h30;
    pattern = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, wa, DW'(8'hC0 + i), 1'b1, ra, wa_d, ra_d, ob_d);
      pattern = {pattern[2:0], ob_d};
      if (wa_d) wa = wa + 6'd1;
      if (ra_d) ra = ra + 6'd1;
    end
    checkOutput("grant pattern WRWR", 32'(pattern), 32'(4'b1010));

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, AW'(i), DW'(8'hA0 + i), 1'b0, '0, wa_d, ra_d, ob_d);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), wa_d, ra_d, ob_d);

    runRandom(400);

    applyStimulus(1'b0, '0, '0, 1'b1, 6'h3F, wa_d, ra_d, ob_d);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    flush_base = exp_data.size();
    model_last = GNT_RD;
`ifdef SPRAM_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    #1;
    checkResetValues("midreset");
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rst_n = 1'b1;
`ifdef SPRAM_INIT_CLEAR_EN
    checkInit();
`endif
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0, wa_d, ra_d, ob_d);
    runRandom(150);

    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("drain[%0d]", k), 32'(rd_idx[k]), 32'(exp_data.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
